// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the requester register blocks, the arbiter and the shared uart_tx.
// The slave modport is the arbiter's view. The master modport is the surrounding system.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   en;
  logic [NUM_REQ-1:0]     req;
  logic [16*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]     ack;
  logic [2:0]             grant_id;
  logic [15:0]            cfg_clk_div;
  logic [4:0]             cfg_bpw;
  logic [15:0]            uart_data;
  logic [15:0]            uart_clk_div;
  logic [4:0]             uart_bpw;
  logic                   uart_wr_en;
  logic                   uart_busy;
  logic                   active;
  logic                   timeout_err;
  logic [15:0]            frame_cnt;

  modport slave (
    input  en, req, req_data, cfg_clk_div, cfg_bpw, uart_busy,
    output ack, grant_id, uart_data, uart_clk_div, uart_bpw, uart_wr_en,
           active, timeout_err, frame_cnt
  );

  modport master (
    output en, req, req_data, cfg_clk_div, cfg_bpw, uart_busy,
    input  ack, grant_id, uart_data, uart_clk_div, uart_bpw, uart_wr_en,
           active, timeout_err, frame_cnt
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer that shares one uart_tx between NUM_REQ requesters.
// Each frame latches one word and a frame-stable copy of the line config.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] DEF_CLK_DIV  = 16'd434,
  parameter logic [4:0]  DEF_BPW      = 5'd7,
  parameter int          BUSY_TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [TW-1:0]      r_wait_cnt;
  logic [IW-1:0]      r_rr;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_wr_en;
  logic [15:0]        r_data;
  logic [15:0]        r_clk_div;
  logic [4:0]         r_bpw;
  logic [2:0]         r_grant_id;
  logic               r_timeout;
  logic [15:0]        r_frame_cnt;
  logic               r_active;

  logic               w_found;
  logic [IW-1:0]      w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_timeout;
  logic               w_done;
  logic               w_grant_edge;

  logic [NUM_REQ-1:0] w_ack_d;
  logic               w_wr_en_d;
  logic [15:0]        w_data_d;
  logic [15:0]        w_clk_div_d;
  logic [4:0]         w_bpw_d;
  logic [2:0]         w_grant_id_d;
  logic [IW-1:0]      w_rr_d;
  logic               w_timeout_d;
  logic [15:0]        w_frame_cnt_d;

  // Scan offsets from highest to lowest so the requester nearest the pointer wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = IW'((int'(r_rr) + i) % NUM_REQ);
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= (r_state == S_WAIT_BUSY) ? r_wait_cnt + TW'(1) : '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE:      if (bus.en && w_found) w_next_state = S_ISSUE;
      S_ISSUE:     w_next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.uart_busy) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_wait_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          w_next_state = S_IDLE;
          w_timeout    = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.uart_busy) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded one cycle early so they can all leave from flops.
  always_comb begin
    w_grant_edge  = (r_state == S_IDLE) && (w_next_state == S_ISSUE);
    w_ack_d       = '0;
    w_wr_en_d     = 1'b0;
    w_data_d      = r_data;
    w_clk_div_d   = r_clk_div;
    w_bpw_d       = r_bpw;
    w_grant_id_d  = r_grant_id;
    w_rr_d        = r_rr;
    w_timeout_d   = r_timeout | w_timeout;
    w_frame_cnt_d = w_done ? r_frame_cnt + 16'd1 : r_frame_cnt;
    if (w_grant_edge) begin
      w_ack_d[w_grant] = 1'b1;
      w_wr_en_d        = 1'b1;
      w_data_d         = bus.req_data[16*w_grant +: 16];
      w_clk_div_d      = bus.cfg_clk_div;
      w_bpw_d          = bus.cfg_bpw;
      w_grant_id_d     = 3'(w_grant);
      w_rr_d           = IW'((int'(w_grant) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack       <= '0;
      r_wr_en     <= 1'b0;
      r_data      <= '0;
      r_clk_div   <= DEF_CLK_DIV;
      r_bpw       <= DEF_BPW;
      r_grant_id  <= '0;
      r_rr        <= '0;
      r_timeout   <= 1'b0;
      r_frame_cnt <= '0;
      r_active    <= 1'b0;
    end else begin
      r_ack       <= w_ack_d;
      r_wr_en     <= w_wr_en_d;
      r_data      <= w_data_d;
      r_clk_div   <= w_clk_div_d;
      r_bpw       <= w_bpw_d;
      r_grant_id  <= w_grant_id_d;
      r_rr        <= w_rr_d;
      r_timeout   <= w_timeout_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_active    <= (w_next_state != S_IDLE);
    end
  end

  assign bus.ack          = r_ack;
  assign bus.uart_wr_en   = r_wr_en;
  assign bus.uart_data    = r_data;
  assign bus.uart_clk_div = r_clk_div;
  assign bus.uart_bpw     = r_bpw;
  assign bus.grant_id     = r_grant_id;
  assign bus.timeout_err  = r_timeout;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.active       = r_active;

endmodule
